// File: rtl/chunk_adder_pkg.sv
// Shared types and helpers for the sliced multi-cycle adder.
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice index; never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chunk_adder_add.sv
// Parametrised combinational ripple adder used as the per-slice adder.
module add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle add/sub, one CHUNK-bit slice per clock with registered carry.
// CHUNK_ADDER_OVF_EN compiles in the signed-overflow capture and flag.
module chunk_adder
  import chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = clog2(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_in;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] sl_s;
  logic             sl_c;
  logic             accept;
  logic             step;
  logic             last;

  add #(CHUNK) u_add (
    .a  (a_q[CHUNK-1:0]),
    .b  (b_q[CHUNK-1:0]),
    .ci (c_q),
    .s  (sl_s),
    .co (sl_c)
  );

  // Result fills from the top so slice 0 ends up in the LSBs.
  if (CHUNK == WIDTH) begin : g_one
    assign res_in = sl_s;
  end else begin : g_many
    assign res_in = {sl_s, res_q[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    accept    = in_ready && in_valid;
    step      = (state_q == RUN);
    last      = step && (idx_q == LAST);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    idx_d  = idx_q;
    res_d  = res_q;
    cout_d = cout_q;
    if (accept) begin
      a_d   = a;
      b_d   = sub ? ~b : b;
      c_d   = sub ? 1'b1 : cin;
      idx_d = '0;
    end else if (step) begin
      a_d   = a_q >> CHUNK;
      b_d   = b_q >> CHUNK;
      c_d   = sl_c;
      idx_d = idx_q + 1'b1;
      res_d = res_in;
      if (last) cout_d = sl_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      idx_q  <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      idx_q  <= idx_d;
      res_q  <= res_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = res_q;
  assign cout = cout_q;

`ifdef CHUNK_ADDER_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;

  always_comb begin
    am_d  = am_q;
    bm_d  = bm_q;
    ovf_d = ovf_q;
    if (accept) begin
      am_d = a[WIDTH-1];
      bm_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (last) begin
      ovf_d = (am_q == bm_q) && (sl_s[CHUNK-1] != am_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_chunk_adder.sv
// Randomized self-checking bench for chunk_adder at WIDTH=16, CHUNK=4.
module tb_chunk_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vec;
  int errs;
  int ncyc;

  chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  // Arithmetic reference: integer add/sub and signed range check.
  function automatic void model(
    input  logic [W-1:0] av,
    input  logic [W-1:0] bv,
    input  logic         ci,
    input  logic         sb,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ov
  );
    int u;
    int r;
    int sa;
    int sbv;
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    if (sb) begin
      u  = int'(av) - int'(bv);
      co = (av >= bv);
      r  = sa - sbv;
    end else begin
      u  = int'(av) + int'(bv) + int'(ci);
      co = (u > 65535);
      r  = sa + sbv + int'(ci);
    end
    s  = u[W-1:0];
    ov = (r > 32767) || (r < -32768);
`ifndef CHUNK_ADDER_OVF_EN
    ov = 1'b0;
`endif
  endfunction

  task automatic accept(
    input logic [W-1:0] av,
    input logic [W-1:0] bv,
    input logic         ci,
    input logic         sb
  );
    int g;
    g = 0;
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    while (in_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    vec++;
    if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL reset_out: sum=%h cout=%b ovf=%b want 0/0/0",
               sum, cout, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] da [4];
    logic [W-1:0] db [4];
    logic         dc [4];
    logic         ds [4];
    logic [W-1:0] es [4];
    logic         ec [4];
    logic         eo [4];
    int cyc;
    da = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005};
    db = '{16'h1111, 16'h0001, 16'h0001, 16'h0007};
    dc = '{1'b0, 1'b0, 1'b0, 1'b1};
    ds = '{1'b0, 1'b0, 1'b0, 1'b1};
    es = '{16'h2345, 16'h0000, 16'h8000, 16'hFFFE};
    ec = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef CHUNK_ADDER_OVF_EN
    eo = '{1'b0, 1'b0, 1'b1, 1'b0};
`else
    eo = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      accept(da[i], db[i], dc[i], ds[i]);
      wait_valid(cyc);
      vec++;
      if (cyc != N) begin
        errs++;
        $display("FAIL dir%0d_lat: got %0d want %0d", i, cyc, N);
      end
      vec++;
      if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
        errs++;
        $display("FAIL dir%0d: sum=%h cout=%b ovf=%b want %h/%b/%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
      handshake();
      vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d_idle: in_ready=%b out_valid=%b", i,
                 in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] av, bv, es;
    logic ci, sb, ec, eo;
    int cyc;
    int stall;
    for (int i = 0; i < 40; i++) begin
      av = W'($urandom); bv = W'($urandom);
      ci = 1'($urandom); sb = 1'($urandom);
      if (i % 8 == 0) bv = av;
      model(av, bv, ci, sb, es, ec, eo);
      accept(av, bv, ci, sb);
      wait_valid(cyc);
      vec++;
      if (cyc != N) begin
        errs++;
        $display("FAIL rnd%0d_lat: got %0d want %0d", i, cyc, N);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      vec++;
      if (sum !== es || cout !== ec || ovf !== eo || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL rnd%0d %h%s%h ci=%b: sum=%h cout=%b ovf=%b v=%b want %h/%b/%b",
                 i, av, sb ? "-" : "+", bv, ci, sum, cout, ovf,
                 out_valid, es, ec, eo);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] av, bv, es, es2;
    logic ec, eo, ec2, eo2;
    int cyc;
    av = 16'h8001; bv = 16'h8002;
    model(av, bv, 1'b0, 1'b0, es, ec, eo);
    accept(av, bv, 1'b0, 1'b0);
    wait_valid(cyc);
    model(16'h4321, 16'h1234, 1'b0, 1'b1, es2, ec2, eo2);
    a = 16'h4321; b = 16'h1234; cin = 1'b0; sub = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          sum !== es || cout !== ec || ovf !== eo) begin
        errs++;
        $display("FAIL bp_hold%0d: v=%b rdy=%b sum=%h cout=%b ovf=%b want 1/0/%h/%b/%b",
                 k, out_valid, in_ready, sum, cout, ovf, es, ec, eo);
      end
    end
    handshake();
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    vec++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_accept: in_ready=%b want 0", in_ready);
    end
    wait_valid(cyc);
    vec++;
    if (cyc != N || sum !== es2 || cout !== ec2 || ovf !== eo2) begin
      errs++;
      $display("FAIL bp_next: lat=%0d sum=%h cout=%b ovf=%b want %0d/%h/%b/%b",
               cyc, sum, cout, ovf, N, es2, ec2, eo2);
    end
    handshake();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] oa [4];
    logic [W-1:0] ob [4];
    logic         oc [4];
    logic         os [4];
    int tacc [4];
    logic [W-1:0] es;
    logic ec, eo;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom);
      oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = oa[0]; b = ob[0]; cin = oc[0]; sub = os[0];
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      tacc[k] = ncyc;
      if (k < 3) begin
        a = oa[k+1]; b = ob[k+1]; cin = oc[k+1]; sub = os[k+1];
      end else begin
        in_valid = 1'b0;
      end
      model(oa[k], ob[k], oc[k], os[k], es, ec, eo);
      wait_valid(cyc);
      vec++;
      if (cyc != N || sum !== es || cout !== ec || ovf !== eo) begin
        errs++;
        $display("FAIL b2b%0d: lat=%0d sum=%h cout=%b ovf=%b want %0d/%h/%b/%b",
                 k, cyc, sum, cout, ovf, N, es, ec, eo);
      end
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL b2b%0d_done1: out_valid=%b in_ready=%b want 0/1",
                 k, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      vec++;
      if (tacc[k] - tacc[k-1] != N + 2) begin
        errs++;
        $display("FAIL b2b_period%0d: got %0d want %0d", k,
                 tacc[k] - tacc[k-1], N + 2);
      end
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    accept(16'hABCD, 16'h1357, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0) begin
      errs++;
      $display("FAIL midrun_rst: out_valid=%b in_ready=%b sum=%h want 0/1/0000",
               out_valid, in_ready, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    accept(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_valid(cyc);
    vec++;
    if (cyc != N || sum !== 16'h0100 || cout !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL midrun_after: lat=%0d sum=%h cout=%b ovf=%b want %0d/0100/0/0",
               cyc, sum, cout, ovf, N);
    end
    handshake();
  endtask

  initial begin
    vec = 0;
    errs = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/chunk_adder.md
# chunk_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, with a ripple carry held in a register between slices. It is the next generation of the 4-bit gate-level adder. It adds operand width, slice width, a subtract mode, signed-overflow detection and valid/ready handshakes on both sides. It sits between operand producers and result consumers wherever a wide add can trade latency for area.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4: bits processed per cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  augend/minuend.
- b  input  WIDTH  addend/subtrahend.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  final carry; for sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid is high at an edge:
  - a is latched into the A shift register.
  - sub ? ~b : b is latched into the B shift register.
  - The carry register is set to sub ? 1 : cin.
  - The MSBs of a and of the effective b are saved for overflow.
  - The slice index is cleared and the FSM moves to RUN.
- RUN: each edge adds the low CHUNK bits of A and B plus the carry register.
  - The CHUNK-bit result is shifted into the top of the result register, which fills LSB slice first.
  - The carry register takes the slice carry-out and A/B shift right by CHUNK.
  - The index increments. After slice NCHUNK-1 the FSM moves to DONE.
- DONE: out_valid=1. sum, cout and ovf are stable.
  - On an edge with out_ready high, the FSM returns to IDLE.
  - There is no bypass: in_ready rises in the cycle after the output handshake.
- ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- in_valid is ignored outside IDLE. Operands need not stay stable after the accepting edge.
- rst at any time, including mid-RUN: immediate return to IDLE. All registers clear. Any in-flight operation is discarded.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.

## Timing
- The accepting edge is E0. The result is registered at edge E0+NCHUNK, and out_valid is high from that edge onward.
- Latency is NCHUNK cycles from acceptance to out_valid.
- Minimum period between accepts is NCHUNK+2 cycles: accept, NCHUNK RUN edges, output handshake, then IDLE.
- CHUNK == WIDTH: a single RUN cycle, latency 1.
- If out_ready is already high when out_valid rises, the handshake occurs at the next edge and DONE lasts exactly one cycle.
- Outputs hold their values under backpressure for any number of cycles.

## Configuration
- CHUNK_ADDER_OVF_EN defined:
  - The MSB capture registers and the ovf logic are compiled in.
  - ovf is registered together with sum and cout at the last RUN edge.
- CHUNK_ADDER_OVF_EN undefined:
  - The capture registers are absent and ovf is tied to 0.
  - The port remains present, and all other behaviour is identical.

## Structure
- Package chunk_adder_pkg holds:
  - the state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a clog2 helper function for the slice index width.
- Sub-module: one instance of the existing parametrised `add` module, `add #(CHUNK)`, as the per-slice combinational adder.
- The FSM, shift registers, carry register and output registers live in chunk_adder.

## Test plan
Defaults apply (WIDTH=16, CHUNK=4).
- a=0x1234, b=0x1111, cin=0, sub=0 -> sum=0x2345, cout=0, ovf=0; out_valid exactly 4 cycles after the accepting edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Exercises carry across every slice.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0; ovf=1 with CHUNK_ADDER_OVF_EN, 0 without.
- sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0. Confirms cin is ignored in subtract mode.
- out_ready held low 3 cycles after out_valid, with in_valid held high throughout:
  - sum, cout and ovf hold; in_ready stays 0;
  - the next operands are accepted on the edge one cycle after the output handshake.
- rst pulsed during the 2nd RUN cycle -> out_valid=0, sum=0, in_ready=1 immediately. A following a=0x00FF, b=0x0001 gives sum=0x0100.
